wb_sram_bridge: RTL and testbench

Wishbone classic slave that fronts N_BANKS OpenRAM 32x256 single-RW-port SRAM macros and maps them into one contiguous word-addressed window at BASE_ADDR. It generates properly timed ack (absent when the macro is wired straight to the bus), and supports a configurable macro read latency, byte-lane writes and bank decode. It sits in user_project_wrapper between the Wishbone slave ports and the SRAM macros' port 0.

---
 rtl/wb_sram_bridge.sv | 158 +++++++++++++++
 tb/tb_wb_sram_bridge.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_bridge.sv
// Wishbone classic slave bridging a word-addressed window onto N_BANKS single-port
// SRAM macros: registered SRAM controls, bank decode, byte-lane writes, timed ack.
module wb_sram_bridge #(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          N_BANKS      = 2,
  parameter int          BANK_AW      = 8,
  parameter int          READ_LATENCY = 1
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [N_BANKS-1:0]      sram_csb,
  output logic                    sram_web,
  output logic [3:0]              sram_wmask,
  output logic [BANK_AW-1:0]      sram_addr,
  output logic [31:0]             sram_din,
  input  logic [32*N_BANKS-1:0]   sram_dout
);

  localparam int BANK_BITS = $clog2(N_BANKS);
  localparam int BSEL_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int W         = BANK_AW + 2 + BANK_BITS;
  localparam int CNT_W     = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, ACK} state_e;

  state_e                    state_q, state_d;
  logic [N_BANKS-1:0]        csb_q, csb_d;
  logic                      web_q, web_d;
  logic [3:0]                wmask_q, wmask_d;
  logic [BANK_AW-1:0]        addr_q, addr_d;
  logic [31:0]               din_q, din_d;
  logic                      ack_q, ack_d;
  logic [31:0]               dat_q, dat_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [BSEL_W-1:0]         bank_q, bank_d;
  logic                      we_q, we_d;

  logic                      hit;
  logic [BSEL_W-1:0]         req_bank;
  logic [N_BANKS-1:0][31:0]  bank_dout;
  logic                      unused_adr;

  // Byte offset bits carry no meaning on a word-wide port.
  assign unused_adr = ^wbs_adr_i[1:0];
  assign bank_dout  = sram_dout;
  assign hit        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:W] == BASE_ADDR[31:W]);

  generate
    if (BANK_BITS > 0) begin : g_bank
      assign req_bank = wbs_adr_i[W-1:BANK_AW+2];
    end else begin : g_nobank
      assign req_bank = '0;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    csb_d   = '1;
    web_d   = web_q;
    wmask_d = wmask_q;
    addr_d  = addr_q;
    din_d   = din_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        if (hit) begin
          bank_d          = req_bank;
          we_d            = wbs_we_i;
          csb_d[req_bank] = 1'b0;
          addr_d          = wbs_adr_i[BANK_AW+1:2];
          if (wbs_we_i) begin
            web_d   = 1'b0;
            wmask_d = wbs_sel_i;
            din_d   = wbs_dat_i;
          end else begin
            web_d   = 1'b1;
            wmask_d = 4'h0;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // The macro has captured at this edge whatever the master does now.
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else if (we_q) begin
          ack_d   = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d   = CNT_W'(READ_LATENCY - 1);
          state_d = RWAIT;
        end
      end
      RWAIT: begin
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          dat_d   = bank_dout[bank_q];
          ack_d   = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      csb_q   <= '1;
      web_q   <= 1'b1;
      wmask_q <= 4'h0;
      addr_q  <= '0;
      din_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      cnt_q   <= '0;
      bank_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
      we_q    <= we_d;
    end
  end

  assign sram_csb   = csb_q;
  assign sram_web   = web_q;
  assign sram_wmask = wmask_q;
  assign sram_addr  = addr_q;
  assign sram_din   = din_q;
  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Directed bench for wb_sram_bridge: one instance at READ_LATENCY=1, one at 3,
// each backed by a behavioural SRAM model whose read data is valid for one cycle only.
module tb_wb_sram_bridge;

  logic        clk, rst;
  logic        cyc, stb, we, use3;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  int          errors = 0;
  int          checks = 0;

  logic        ack1, web1, ack3, web3;
  logic [31:0] dato1, din1, dato3, din3;
  logic [1:0]  csb1, csb3;
  logic [3:0]  wmask1, wmask3;
  logic [7:0]  addr1, addr3;
  logic [63:0] dout1, dout3;
  logic        cyc1, stb1, cyc3, stb3;

  logic        ack_m;
  logic [31:0] dat_m;
  logic [1:0]  csb_m;

  assign cyc1  = cyc & ~use3;
  assign stb1  = stb & ~use3;
  assign cyc3  = cyc & use3;
  assign stb3  = stb & use3;
  assign ack_m = use3 ? ack3 : ack1;
  assign dat_m = use3 ? dato3 : dato1;
  assign csb_m = use3 ? csb3 : csb1;

  wb_sram_bridge #(.READ_LATENCY(1)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc1), .wbs_stb_i(stb1), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack1), .wbs_dat_o(dato1),
    .sram_csb(csb1), .sram_web(web1), .sram_wmask(wmask1), .sram_addr(addr1),
    .sram_din(din1), .sram_dout(dout1));

  wb_sram_bridge #(.READ_LATENCY(3)) u_dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc3), .wbs_stb_i(stb3), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack3), .wbs_dat_o(dato3),
    .sram_csb(csb3), .sram_web(web3), .sram_wmask(wmask3), .sram_addr(addr3),
    .sram_din(din3), .sram_dout(dout3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM models; word w of bank b powers up as C0DE_0000 | b<<8 | w.
  logic [31:0] mem1 [0:1][0:255];
  logic [31:0] mem3 [0:1][0:255];
  logic [31:0] rd1  [0:1];
  logic [31:0] p3   [0:1][0:2];

  initial begin
    for (int b = 0; b < 2; b++)
      for (int w = 0; w < 256; w++) begin
        mem1[b][w] = 32'hC0DE_0000 | (b << 8) | w;
        mem3[b][w] = 32'hC0DE_0000 | (b << 8) | w;
      end
  end

  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      rd1[b] <= 32'hBAD0_BAD0;
      if (!csb1[b]) begin
        if (!web1) begin
          for (int i = 0; i < 4; i++)
            if (wmask1[i]) mem1[b][addr1][8*i +: 8] <= din1[8*i +: 8];
        end else begin
          rd1[b] <= mem1[b][addr1];
        end
      end
    end
  end
  assign dout1 = {rd1[1], rd1[0]};

  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      p3[b][0] <= 32'hBAD0_BAD0;
      p3[b][1] <= p3[b][0];
      p3[b][2] <= p3[b][1];
      if (!csb3[b]) begin
        if (!web3) begin
          for (int i = 0; i < 4; i++)
            if (wmask3[i]) mem3[b][addr3][8*i +: 8] <= din3[8*i +: 8];
        end else begin
          p3[b][0] <= mem3[b][addr3];
        end
      end
    end
  end
  assign dout3 = {p3[1][2], p3[0][2]};

  // Driver: call just after a posedge; returns just after a posedge with the bus idle.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int maxc, output int lat,
                      output logic [31:0] rd, output logic [1:0] csb_k1,
                      output logic [7:0] addr_k1, output logic [3:0] wm_k1, output int acc);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    lat = 0; acc = 0; rd = '0; csb_k1 = '1; addr_k1 = '0; wm_k1 = '0;
    @(posedge clk);
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      if (csb_m != 2'b11) acc++;
      if (k == 1) begin
        csb_k1  = csb_m;
        addr_k1 = use3 ? addr3 : addr1;
        wm_k1   = use3 ? wmask3 : wmask1;
      end
      if (ack_m) begin
        lat = k; rd = dat_m;
        break;
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  int          lat, acc;
  logic [31:0] rd;
  logic [1:0]  ck1;
  logic [7:0]  ak1;
  logic [3:0]  wk1;

  task automatic test_reset();
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; dat = '0; use3 = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (csb1 !== 2'b11 || csb3 !== 2'b11) begin errors++; $display("FAIL reset_csb: got %b/%b want 11", csb1, csb3); end
    checks++; if (ack1 !== 1'b0 || dato1 !== 32'h0) begin errors++; $display("FAIL reset_ack_dat: got ack=%b dat=%h want 0/0", ack1, dato1); end
    checks++; if (web1 !== 1'b1 || wmask1 !== 4'h0 || addr1 !== 8'h0 || din1 !== 32'h0) begin
      errors++; $display("FAIL reset_sram: got web=%b wmask=%h addr=%h din=%h want 1/0/0/0", web1, wmask1, addr1, din1); end
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (csb1 !== 2'b11 || ack1 !== 1'b0 || dato3 !== 32'h0) begin
      errors++; $display("FAIL reset_release: got csb=%b ack=%b dat3=%h want 11/0/0", csb1, ack1, dato3); end
  endtask

  task automatic test_write_read();
    xfer(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 12, lat, rd, ck1, ak1, wk1, acc);
    checks++; if (lat != 2) begin errors++; $display("FAIL wr_ack_lat: got %0d want 2", lat); end
    checks++; if (ck1 !== 2'b10 || ak1 !== 8'd1 || wk1 !== 4'hF) begin
      errors++; $display("FAIL wr_issue: got csb=%b addr=%h wmask=%h want 10/01/f", ck1, ak1, wk1); end
    checks++; if (acc != 1) begin errors++; $display("FAIL wr_csb_cycles: got %0d want 1", acc); end
    xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, 12, lat, rd, ck1, ak1, wk1, acc);
    checks++; if (lat != 3) begin errors++; $display("FAIL rd_ack_lat: got %0d want 3", lat); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    checks++; if (ck1 !== 2'b10 || acc != 1) begin errors++; $display("FAIL rd_issue: got csb=%b acc=%0d want 10/1", ck1, acc); end
  endtask

  task automatic test_byte_lanes();
    xfer(1'b1, 32'h3000_0400, 32'h1122_3344, 4'hF, 12, lat, rd, ck1, ak1, wk1, acc);
    checks++; if (ck1 !== 2'b01 || ak1 !== 8'd0 || lat != 2) begin
      errors++; $display("FAIL bank1_wr: got csb=%b addr=%h lat=%0d want 01/00/2", ck1, ak1, lat); end
    xfer(1'b1, 32'h3000_0400, 32'hAABB_CCDD, 4'b0101, 12, lat, rd, ck1, ak1, wk1, acc);
    checks++; if (wk1 !== 4'b0101) begin errors++; $display("FAIL lane_wmask: got %b want 0101", wk1); end
    xfer(1'b0, 32'h3000_0403, 32'h0, 4'hF, 12, lat, rd, ck1, ak1, wk1, acc);
    checks++; if (rd !== 32'h11BB_33DD || ck1 !== 2'b01) begin
      errors++; $display("FAIL lane_merge: got %h csb=%b want 11bb33dd/01", rd, ck1); end
    xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, 12, lat, rd, ck1, ak1, wk1, acc);
    checks++; if (rd !== 32'hC0DE_0000) begin errors++; $display("FAIL bank0_w0: got %h want c0de0000", rd); end
    xfer(1'b1, 32'h3000_0004, 32'hFFFF_FFFF, 4'h0, 12, lat, rd, ck1, ak1, wk1, acc);
    checks++; if (lat != 2 || wk1 !== 4'h0) begin errors++; $display("FAIL sel0_wr: got lat=%0d wmask=%h want 2/0", lat, wk1); end
    checks++; if (dato1 !== 32'hC0DE_0000) begin errors++; $display("FAIL dat_hold_wr: got %h want c0de0000", dato1); end
    xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, 12, lat, rd, ck1, ak1, wk1, acc);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sel0_nochange: got %h want deadbeef", rd); end
  endtask

  task automatic test_miss();
    xfer(1'b0, 32'h3000_0800, 32'h0, 4'hF, 12, lat, rd, ck1, ak1, wk1, acc);
    checks++; if (lat != 0 || acc != 0) begin errors++; $display("FAIL miss: got lat=%0d csb_cycles=%0d want 0/0", lat, acc); end
    checks++; if (dato1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL miss_dat: got %h want deadbeef", dato1); end
  endtask

  task automatic test_abort();
    int nack, nlow;
    // Read dropped in RWAIT.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0400; sel = 4'hF;
    @(posedge clk); @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    nack = 0;
    for (int k = 0; k < 6; k++) begin @(negedge clk); if (ack1) nack++; end
    checks++; if (nack != 0 || dato1 !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL abort_rd: got acks=%0d dat=%h want 0/deadbeef", nack, dato1); end
    @(posedge clk); #1;
    xfer(1'b0, 32'h3000_0400, 32'h0, 4'hF, 12, lat, rd, ck1, ak1, wk1, acc);
    checks++; if (lat != 3 || rd !== 32'h11BB_33DD) begin
      errors++; $display("FAIL after_abort_rd: got lat=%0d dat=%h want 3/11bb33dd", lat, rd); end
    // Write dropped in ISSUE still lands.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0008; dat = 32'hCAFE_F00D; sel = 4'hF;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    nack = 0; nlow = 0;
    for (int k = 0; k < 6; k++) begin @(negedge clk); if (ack1) nack++; if (csb1 != 2'b11) nlow++; end
    checks++; if (nack != 0 || nlow != 1) begin errors++; $display("FAIL abort_wr: got acks=%0d csb_cycles=%0d want 0/1", nack, nlow); end
    @(posedge clk); #1;
    xfer(1'b0, 32'h3000_0008, 32'h0, 4'hF, 12, lat, rd, ck1, ak1, wk1, acc);
    checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL abort_wr_lands: got %h want cafef00d", rd); end
  endtask

  task automatic test_latency();
    int nack;
    logic stable;
    use3 = 1'b1;
    xfer(1'b1, 32'h3000_0004, 32'h1234_5678, 4'hF, 12, lat, rd, ck1, ak1, wk1, acc);
    checks++; if (lat != 2) begin errors++; $display("FAIL l3_wr_lat: got %0d want 2", lat); end
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0004; sel = 4'hF;
    @(posedge clk);
    lat = 0; nack = 0; stable = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ack3) begin nack++; if (lat == 0) lat = k; end
      if (lat != 0 && dato3 !== 32'h1234_5678) stable = 1'b0;
      if (k == 6) begin cyc = 1'b0; stb = 1'b0; end
    end
    checks++; if (lat != 5) begin errors++; $display("FAIL l3_rd_lat: got %0d want 5", lat); end
    checks++; if (nack != 1) begin errors++; $display("FAIL l3_ack_pulse: got %0d ack cycles want 1", nack); end
    checks++; if (!stable) begin errors++; $display("FAIL l3_dat_stable: got %h want 12345678", dato3); end
    @(posedge clk); #1;
    xfer(1'b0, 32'h3000_0414, 32'h0, 4'hF, 12, lat, rd, ck1, ak1, wk1, acc);
    checks++; if (lat != 5 || rd !== 32'hC0DE_0105 || ck1 !== 2'b01) begin
      errors++; $display("FAIL l3_bank1: got lat=%0d dat=%h csb=%b want 5/c0de0105/01", lat, rd, ck1); end
    use3 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int t_ack1, t_csb2, t_ack2, low;
    logic [31:0] d1, d2;
    t_ack1 = 0; t_csb2 = 0; t_ack2 = 0; low = 0; d1 = '0; d2 = '0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0004; sel = 4'hF;
    @(posedge clk);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (csb1 != 2'b11) begin low++; if (t_ack1 != 0 && t_csb2 == 0) t_csb2 = k; end
      if (ack1) begin
        if (t_ack1 == 0) begin t_ack1 = k; d1 = dato1; end
        else begin t_ack2 = k; d2 = dato1; break; end
      end
      if (t_ack1 == k) begin @(posedge clk); #1; adr = 32'h3000_0008; end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    checks++; if (t_ack1 != 3 || d1 !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL b2b_first: got t=%0d dat=%h want 3/deadbeef", t_ack1, d1); end
    checks++; if (t_csb2 - t_ack1 != 2) begin errors++; $display("FAIL b2b_gap: got %0d want 2", t_csb2 - t_ack1); end
    checks++; if (t_ack2 != 7 || d2 !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL b2b_second: got t=%0d dat=%h want 7/cafef00d", t_ack2, d2); end
    checks++; if (low != 2) begin errors++; $display("FAIL b2b_accesses: got %0d want 2", low); end
  endtask

  task automatic test_reset_mid();
    int nack, nlow;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_000C; dat = 32'h0BAD_F00D; sel = 4'hF;
    @(posedge clk); #2;
    checks++; if (csb1 !== 2'b10) begin errors++; $display("FAIL rmid_pre: got csb=%b want 10", csb1); end
    rst = 1'b1;
    #1;
    checks++; if (csb1 !== 2'b11 || ack1 !== 1'b0 || dato1 !== 32'h0) begin
      errors++; $display("FAIL rmid_async: got csb=%b ack=%b dat=%h want 11/0/0", csb1, ack1, dato1); end
    checks++; if (web1 !== 1'b1 || wmask1 !== 4'h0 || addr1 !== 8'h0 || din1 !== 32'h0) begin
      errors++; $display("FAIL rmid_sram: got web=%b wmask=%h addr=%h din=%h want 1/0/0/0", web1, wmask1, addr1, din1); end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b0;
    nack = 0; nlow = 0;
    for (int k = 0; k < 6; k++) begin @(negedge clk); if (ack1) nack++; if (csb1 != 2'b11) nlow++; end
    checks++; if (nack != 0 || nlow != 0) begin errors++; $display("FAIL rmid_quiet: got acks=%0d csb_cycles=%0d want 0/0", nack, nlow); end
    @(posedge clk); #1;
    xfer(1'b0, 32'h3000_000C, 32'h0, 4'hF, 12, lat, rd, ck1, ak1, wk1, acc);
    checks++; if (lat != 3 || rd !== 32'hC0DE_0003) begin
      errors++; $display("FAIL rmid_nowrite: got lat=%0d dat=%h want 3/c0de0003", lat, rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_miss();
    test_abort();
    test_latency();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
